// File: rtl/calc_entry_pkg.sv
// Shared key-command, operator and state encodings for the calculator entry stage.
`default_nettype none

package calc_entry_pkg;

  localparam int IC_N = 5;
  typedef logic [IC_N-1:0] ic_t;

  localparam ic_t IC_NONE = 5'd0;
  localparam ic_t IC_D0   = 5'd1;
  localparam ic_t IC_D1   = 5'd2;
  localparam ic_t IC_D2   = 5'd3;
  localparam ic_t IC_D3   = 5'd4;
  localparam ic_t IC_D4   = 5'd5;
  localparam ic_t IC_D5   = 5'd6;
  localparam ic_t IC_D6   = 5'd7;
  localparam ic_t IC_D7   = 5'd8;
  localparam ic_t IC_D8   = 5'd9;
  localparam ic_t IC_D9   = 5'd10;
  localparam ic_t IC_ADD  = 5'd11;
  localparam ic_t IC_SUB  = 5'd12;
  localparam ic_t IC_MUL  = 5'd13;
  localparam ic_t IC_DIV  = 5'd14;
  localparam ic_t IC_EQ   = 5'd15;
  localparam ic_t IC_CLR  = 5'd16;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_REQ  = 3'd3,
    S_WAIT = 3'd4,
    S_SHOW = 3'd5,
    S_ERR  = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/calc_entry_acc.sv
// Decimal digit accumulator: val*10+d with DIGITS saturation and leading-zero suppression.
`default_nettype none

module calc_entry_acc #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [3:0]       d,
  output logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] val_next
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [WIDTH-1:0] TEN = WIDTH'(10);
  localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  always_comb begin
    val_next   = val;
    count_next = count;
    if (clr) begin
      val_next   = '0;
      count_next = '0;
    end else if (load) begin
      val_next   = WIDTH'(d);
      count_next = (d != 4'd0) ? CW'(1) : CW'(0);
    end else if (shift) begin
      // Zeros typed while the operand is still zero are not significant digits.
      if (!(val == '0 && d == 4'd0) && count < MAX_CNT) begin
        val_next   = val * TEN + WIDTH'(d);
        count_next = count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val   <= '0;
      count <= '0;
    end else begin
      val   <= val_next;
      count <= count_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/calc_entry.sv
// Calculator operand/operator entry: consumes key commands, issues arithmetic requests, shows results.
`default_nettype none

module calc_entry
  import calc_entry_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  ic_t              cmd,
  output logic             ack,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [WIDTH-1:0] req_a,
  output logic [WIDTH-1:0] req_b,
  output logic [1:0]       req_op,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_val,
  input  logic             res_err,
  output logic [WIDTH-1:0] disp_val,
  output logic             disp_err
);

  state_t state, state_d;
  op_t    op, next_op, key_op;
  logic   pending;
  logic [WIDTH-1:0] a, val, val_next;
  logic   is_dig, is_opk, is_eq, is_clr;
  logic [3:0] dig;
  logic   acc_clr, acc_load, acc_shift;

  always_comb begin
    is_dig = (cmd >= IC_D0) && (cmd <= IC_D9);
    is_opk = (cmd >= IC_ADD) && (cmd <= IC_DIV);
    is_eq  = (cmd == IC_EQ);
    is_clr = (cmd == IC_CLR);
    dig    = 4'(cmd - IC_D0);
    key_op = op_t'(2'(cmd - IC_ADD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_A;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    ack     = 1'b0;
    case (state)
      S_A: begin
        ack = (cmd != IC_NONE);
        if (is_opk) state_d = S_OP;
      end
      S_OP: begin
        ack = (cmd != IC_NONE);
        if (is_dig) state_d = S_B;
      end
      S_B: begin
        ack = (cmd != IC_NONE);
        if (is_opk || is_eq) state_d = S_REQ;
      end
      S_REQ: begin
        if (req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_valid) state_d = res_err ? S_ERR : (pending ? S_OP : S_SHOW);
      end
      S_SHOW: begin
        ack = (cmd != IC_NONE);
        if (is_dig)      state_d = S_A;
        else if (is_opk) state_d = S_OP;
      end
      S_ERR: begin
        ack = is_clr;
      end
      default: state_d = S_A;
    endcase
    if (ack && is_clr) state_d = S_A;
  end

  always_comb begin
    acc_clr   = ack && is_clr;
    acc_load  = ack && is_dig && (state == S_OP || state == S_SHOW);
    acc_shift = ack && is_dig && (state == S_A || state == S_B);
  end

  calc_entry_acc #(.DIGITS(DIGITS), .WIDTH(WIDTH)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .load     (acc_load),
    .shift    (acc_shift),
    .d        (dig),
    .val      (val),
    .val_next (val_next)
  );

  // req_b doubles as the latched right operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= '0;
      op        <= OP_ADD;
      next_op   <= OP_ADD;
      pending   <= 1'b0;
      disp_val  <= '0;
      disp_err  <= 1'b0;
      req_valid <= 1'b0;
      req_a     <= '0;
      req_b     <= '0;
      req_op    <= OP_ADD;
    end else if (ack && is_clr) begin
      a        <= '0;
      req_b    <= '0;
      pending  <= 1'b0;
      disp_val <= '0;
      disp_err <= 1'b0;
    end else begin
      case (state)
        S_A, S_OP, S_B, S_SHOW: begin
          if (ack && is_dig) begin
            disp_val <= val_next;
            if (state == S_SHOW) a <= '0;
          end else if (ack && is_opk) begin
            op <= key_op;
            if (state == S_A) a <= val;
          end
          if (state == S_B && ack && (is_opk || is_eq)) begin
            req_valid <= 1'b1;
            req_a     <= a;
            req_b     <= val;
            req_op    <= op;
            pending   <= is_opk;
            next_op   <= key_op;
          end
        end
        S_REQ: begin
          if (req_ready) req_valid <= 1'b0;
        end
        S_WAIT: begin
          if (res_valid) begin
            if (res_err) begin
              disp_err <= 1'b1;
            end else begin
              a        <= res_val;
              disp_val <= res_val;
              if (pending) op <= next_op;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_calc_entry.sv
// Directed self-checking bench for calc_entry; the bench plays scanner and arithmetic unit.
`default_nettype none

module tb_calc_entry;
  import calc_entry_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  ic_t         cmd = IC_NONE;
  logic        ack;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [15:0] req_a, req_b;
  logic [1:0]  req_op;
  logic        res_valid = 1'b0;
  logic [15:0] res_val = '0;
  logic        res_err = 1'b0;
  logic [15:0] disp_val;
  logic        disp_err;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int base;

  calc_entry #(.DIGITS(4), .WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd),
    .ack       (ack),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .res_valid (res_valid),
    .res_val   (res_val),
    .res_err   (res_err),
    .disp_val  (disp_val),
    .disp_err  (disp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && ack) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one key and hold it until the DUT consumes it.
  task automatic press(input ic_t k);
    int n;
    n = 0;
    @(negedge clk);
    cmd = k;
    #1;
    while (!ack && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ack) check("press_ack", ack, 1);
    @(posedge clk);
    #1 cmd = IC_NONE;
  endtask

  // Act as the arithmetic unit for one request.
  task automatic serve(input logic [15:0] ea, input logic [15:0] eb, input logic [1:0] eop,
                       input int stall, input logic [15:0] rv, input logic re);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (!req_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("req_valid", req_valid, 1);
    check("req_a", req_a, ea);
    check("req_b", req_b, eb);
    check("req_op", req_op, eop);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      check("hold_valid", req_valid, 1);
      check("hold_a", req_a, ea);
      check("hold_b", req_b, eb);
      check("hold_ack", ack, 0);
    end
    req_ready = 1'b1;
    @(posedge clk);
    #1 req_ready = 1'b0;
    check("req_drop", req_valid, 0);
    check("wait_ack", ack, 0);
    @(negedge clk);
    res_valid = 1'b1;
    res_val   = rv;
    res_err   = re;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    res_err   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_valid", req_valid, 0);
    check("rst_disp", disp_val, 0);
    check("rst_err", disp_err, 0);
    check("rst_ack", ack, 0);

    // 12 + 3 =
    base = ack_cnt;
    press(IC_D1); press(IC_D2); press(IC_ADD); press(IC_D3); press(IC_EQ);
    check("ack_per_key", ack_cnt - base, 5);
    serve(16'd12, 16'd3, OP_ADD, 0, 16'd15, 1'b0);
    check("show_15", disp_val, 15);
    press(IC_CLR);
    check("clr_disp", disp_val, 0);

    // Digit saturation
    base = ack_cnt;
    repeat (5) press(IC_D9);
    check("sat_acks", ack_cnt - base, 5);
    check("sat_9999", disp_val, 9999);
    press(IC_CLR);

    // Leading zeros are not counted
    press(IC_D0); press(IC_D0);
    check("lead_zero", disp_val, 0);
    press(IC_D1); press(IC_D2); press(IC_D3); press(IC_D4);
    check("lead_1234", disp_val, 1234);
    press(IC_CLR);

    // Chained 5 * 2 - 4 =, with a key pending across the request
    press(IC_D5); press(IC_MUL); press(IC_D2); press(IC_SUB);
    @(negedge clk);
    cmd = IC_D4;
    serve(16'd5, 16'd2, OP_MUL, 3, 16'd10, 1'b0);
    check("chain_disp", disp_val, 10);
    check("chain_ack", ack, 1);
    @(posedge clk);
    #1 cmd = IC_NONE;
    check("chain_b_disp", disp_val, 4);
    press(IC_EQ);
    serve(16'd10, 16'd4, OP_SUB, 0, 16'd6, 1'b0);
    check("chain_show", disp_val, 6);

    // 8 / 0 = -> error
    press(IC_D8); press(IC_DIV); press(IC_D0); press(IC_EQ);
    serve(16'd8, 16'd0, OP_DIV, 0, 16'd0, 1'b1);
    check("err_set", disp_err, 1);
    @(negedge clk);
    cmd = IC_D1;
    #1 check("err_digit_ack", ack, 0);
    repeat (2) @(negedge clk);
    #1 check("err_digit_hold", ack, 0);
    cmd = IC_CLR;
    #1 check("err_clr_ack", ack, 1);
    @(posedge clk);
    #1 cmd = IC_NONE;
    check("err_clr", disp_err, 0);
    check("err_clr_disp", disp_val, 0);

    // Stray result strobe in S_A, then operator replacement
    @(negedge clk);
    res_valid = 1'b1;
    res_val   = 16'd999;
    @(negedge clk);
    res_valid = 1'b0;
    #1 check("stray_res", disp_val, 0);
    press(IC_D7); press(IC_ADD); press(IC_ADD); press(IC_MUL); press(IC_D3); press(IC_EQ);
    serve(16'd7, 16'd3, OP_MUL, 0, 16'd21, 1'b0);
    check("mul_show", disp_val, 21);

    // Reset asserted while a request is outstanding
    press(IC_D1); press(IC_SUB); press(IC_D2); press(IC_EQ);
    @(negedge clk);
    #1 check("pre_rst_valid", req_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", req_valid, 0);
    check("mid_rst_a", req_a, 0);
    check("mid_rst_b", req_b, 0);
    check("mid_rst_op", req_op, 0);
    check("mid_rst_disp", disp_val, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_ack", ack, 0);
    press(IC_D6);
    check("post_rst_digit", disp_val, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/calc_entry.md
Name: calc_entry

Overview:
- Operand/operator entry stage directly downstream of the keypad scanner.
- Consumes one scanned key command at a time over the `cmd`/`ack` handshake.
- Accumulates decimal digits into binary operands and tracks the pending operator.
- Issues {a, b, op} requests to the arithmetic unit over valid/ready, then captures the result for display and for chained operations.

Parameters:
- DIGITS, 4, maximum decimal digits per operand; further digits are consumed and ignored.
- WIDTH, 16, operand/result/display width in bits; must satisfy 10^DIGITS-1 < 2^WIDTH.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- cmd  input  IC_N  key command from the scanner; IC_NONE means no key pending.
- ack  output  1  consume strobe: cmd is taken on the rising edge where ack=1, and the scanner returns cmd to IC_NONE on that edge.
- req_valid  output  1  arithmetic request valid.
- req_ready  input  1  arithmetic unit accepts the request.
- req_a  output  WIDTH  left operand.
- req_b  output  WIDTH  right operand.
- req_op  output  2  OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
- res_valid  input  1  one-cycle result strobe.
- res_val  input  WIDTH  result value.
- res_err  input  1  qualifies res_valid: overflow or divide-by-zero.
- disp_val  output  WIDTH  value currently shown.
- disp_err  output  1  error indicator.

Behaviour:
- Interface: one clock (Clock); Reset is asynchronous and active-low.
- Reset values: state=S_A; val, a, b, disp_val, req_a, req_b = 0; req_op=OP_ADD; req_valid=0; disp_err=0; digit count=0; pending flag=0.
- ack is combinational: ack = (cmd != IC_NONE) && state in {S_A, S_OP, S_B, S_SHOW, S_ERR}.
  - In S_ERR, ack is high only when cmd==IC_CLR; every other key is left pending and not consumed.
  - In S_REQ and S_WAIT, ack=0 and the key stays pending in the scanner.
- Digit entry, when a digit d is consumed:
  - If count<DIGITS: val <= val*10+d, count++.
  - Otherwise: value unchanged, key still consumed.
  - Leading zeros do not increment count while val==0.
  - disp_val tracks the operand being entered.
- States and transitions:
  - S_A (entering a):
    - digit: accumulate into val.
    - op key: a<=val, op<=key, go to S_OP.
    - IC_EQ: no effect.
  - S_OP (operator latched):
    - op key: replaces op.
    - digit: val<=d, count=(d!=0), go to S_B.
    - IC_EQ: no effect.
  - S_B (entering b):
    - digit: accumulate into val.
    - op key: b<=val; request {a, val, op}; pending<=1; next<=key; go to S_REQ.
    - IC_EQ: same request, pending<=0, go to S_REQ.
  - S_REQ:
    - req_valid=1 with req_a, req_b, req_op stable until req_valid && req_ready.
    - On handshake: req_valid<=0 on the next edge, go to S_WAIT.
  - S_WAIT: on res_valid:
    - res_err: disp_err<=1, go to S_ERR.
    - else if pending: a<=res_val, op<=next, disp_val<=res_val, go to S_OP.
    - else: disp_val<=res_val, a<=res_val, go to S_SHOW.
  - S_SHOW:
    - digit: val<=d, a discarded, go to S_A.
    - op key: op<=key, go to S_OP (result chains as a).
    - IC_EQ: no effect.
  - S_ERR: only IC_CLR is accepted; it clears disp_err and exits as below.
- IC_CLR in any accepting state: val=a=b=0, count=0, pending=0, disp_val=0, disp_err=0, go to S_A.
- res_valid outside S_WAIT is ignored.
- Arithmetic: val*10+d is computed at WIDTH bits; by the DIGITS constraint it never wraps.
- Reset asserted mid-request: req_valid drops immediately (asynchronous) and all state returns to reset values.

Decomposition:
- Shared include INPUT_INTERFACE.v holds:
  - IC_N=5.
  - IC_NONE=0, IC_D0..IC_D9=1..10.
  - IC_ADD=11, IC_SUB=12, IC_MUL=13, IC_DIV=14, IC_EQ=15, IC_CLR=16.
  - OP_* encodings and state encodings.
- One sub-module, calc_entry_acc: the digit accumulator (val, count, DIGITS saturation, leading-zero rule), with clear/load/shift controls.

Test Plan:
- Reset low mid-run, then high → all outputs at reset values; ack=0 while cmd=IC_NONE.
- Keys 1,2,+,3,= with req_ready=1 and res 15 → one request a=12 b=3 op=ADD; ack pulses exactly once per key; disp_val=15 in S_SHOW.
- Keys 9,9,9,9,9 → val=9999; fifth key acked with no change.
- Keys 5,*,2,- (chained): req held valid with req_ready=0 for 3 cycles, operands stable; ack=0 for a cmd presented during S_REQ/S_WAIT. Then res 10 → disp_val=10, state S_OP with op=SUB; keys 4,= → request a=10 b=4 op=SUB.
- Keys 8,/,0,= with res_err=1 → disp_err=1; IC_D1 not acked; IC_CLR acked → disp_err=0, disp_val=0.
- Keys 7,+,+ then replace with × → request on 3,= carries op=MUL; res_valid strobe in S_A is ignored.
